// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared types for the count-enable generator
package counter_pkg;

    typedef enum logic {
        MODE_BTN      = 1'b0,
        MODE_PRESCALE = 1'b1
    } mode_e;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_PRESS_CHK = 2'd1,
        S_HELD      = 2'd2,
        S_REL_CHK   = 2'd3
    } dbc_state_e;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - two-flop synchroniser plus debounce FSM with single press pulse
module btn_debounce
    import counter_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn,
    output logic o_level,
    output logic o_press_pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q;
    logic          btn_s;
    dbc_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          press;

    assign btn_s = sync_q[1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        press   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (btn_s) begin
                    state_d = S_PRESS_CHK;
                    cnt_d   = '0;
                end
            end
            S_PRESS_CHK: begin
                if (!btn_s) begin
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_HELD;
                    level_d = 1'b1;
                    press   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_HELD: begin
                if (!btn_s) begin
                    state_d = S_REL_CHK;
                    cnt_d   = '0;
                end
            end
            S_REL_CHK: begin
                if (btn_s) begin
                    state_d = S_HELD;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_IDLE;
                    level_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q  <= 2'b00;
            state_q <= S_IDLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], i_btn};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    // press is the combinational accept condition; the top registers it into o_enable
    assign o_level       = level_q;
    assign o_press_pulse = press;

endmodule

// File: rtl/count_enable_gen.sv
// rtl/count_enable_gen.sv - count-enable strobe from debounced button or prescaler tick
module count_enable_gen
    import counter_pkg::*;
#(
    parameter int PRESCALE_DIV    = 4,
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn,
    input  logic i_mode,
    input  logic i_run,
    output logic o_enable,
    output logic o_btn_level
);

    localparam int PW = $clog2(PRESCALE_DIV) + 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE_DIV - 1);

    logic          press_pulse;
    logic [PW-1:0] pre_cnt_q, pre_cnt_d;
    logic          tick;
    logic          enable_q, enable_d;
    logic          mode_pre;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_btn         (i_btn),
        .o_level       (o_btn_level),
        .o_press_pulse (press_pulse)
    );

    assign mode_pre = (i_mode == MODE_PRESCALE);

    // Button mode parks the prescaler at zero so a fresh period starts on mode entry
    always_comb begin
        pre_cnt_d = pre_cnt_q;
        tick      = 1'b0;
        if (!mode_pre) begin
            pre_cnt_d = '0;
        end else if (i_run) begin
            if (pre_cnt_q == PRE_LAST) begin
                tick      = 1'b1;
                pre_cnt_d = '0;
            end else begin
                pre_cnt_d = pre_cnt_q + 1'b1;
            end
        end
    end

    assign enable_d = i_run & (mode_pre ? tick : press_pulse);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pre_cnt_q <= '0;
            enable_q  <= 1'b0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
            enable_q  <= enable_d;
        end
    end

    assign o_enable = enable_q;

endmodule

// File: tb/tb_count_enable_gen.sv
// tb/tb_count_enable_gen.sv - directed self-checking bench for count_enable_gen
module tb_count_enable_gen;

    logic clk;
    logic rst_n;
    logic btn;
    logic mode;
    logic run;
    logic en4, lvl4;
    logic en1, lvl1;

    int n_checks;
    int n_fail;

    count_enable_gen #(.PRESCALE_DIV(4), .DEBOUNCE_CYCLES(4)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_btn       (btn),
        .i_mode      (mode),
        .i_run       (run),
        .o_enable    (en4),
        .o_btn_level (lvl4)
    );

    count_enable_gen #(.PRESCALE_DIV(1), .DEBOUNCE_CYCLES(4)) dut_div1 (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_btn       (btn),
        .i_mode      (mode),
        .i_run       (run),
        .o_enable    (en1),
        .o_btn_level (lvl1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs n cycles, recording which cycles had o_enable high and when the level first rose/fell
    task automatic observe(input int n, output logic [31:0] mask, output int rise, output int fall);
        logic prev;
        mask = '0;
        rise = -1;
        fall = -1;
        prev = lvl4;
        for (int c = 1; c <= n; c++) begin
            step();
            if (en4) mask[c] = 1'b1;
            if (lvl4 && !prev && rise < 0) rise = c;
            if (!lvl4 && prev && fall < 0) fall = c;
            prev = lvl4;
        end
    endtask

    task automatic test_reset();
        logic [31:0] m;
        int r, f;
        rst_n = 1'b0; btn = 1'b1; mode = 1'b0; run = 1'b1;
        repeat (3) step();
        n_checks++;
        if (en4 !== 1'b0) begin n_fail++; $display("FAIL reset_enable: got %b want 0", en4); end
        n_checks++;
        if (lvl4 !== 1'b0) begin n_fail++; $display("FAIL reset_level: got %b want 0", lvl4); end
        n_checks++;
        if (en1 !== 1'b0) begin n_fail++; $display("FAIL reset_enable_div1: got %b want 0", en1); end
        btn = 1'b0;
        rst_n = 1'b1;
        observe(20, m, r, f);
        n_checks++;
        if (m !== 32'h0) begin n_fail++; $display("FAIL reset_idle_pulses: got %h want 0", m); end
        n_checks++;
        if (lvl4 !== 1'b0) begin n_fail++; $display("FAIL reset_idle_level: got %b want 0", lvl4); end
    endtask

    task automatic test_clean_press();
        logic [31:0] m;
        int r, f;
        mode = 1'b0; run = 1'b1;
        btn = 1'b1;
        observe(20, m, r, f);
        n_checks++;
        if (m !== 32'h0000_0080) begin n_fail++; $display("FAIL press_pulse_mask: got %h want 00000080", m); end
        n_checks++;
        if (r !== 7) begin n_fail++; $display("FAIL press_level_rise: got %0d want 7", r); end
        n_checks++;
        if (lvl4 !== 1'b1) begin n_fail++; $display("FAIL press_level_held: got %b want 1", lvl4); end
        btn = 1'b0;
        observe(20, m, r, f);
        n_checks++;
        if (m !== 32'h0) begin n_fail++; $display("FAIL release_pulse_mask: got %h want 0", m); end
        n_checks++;
        if (f !== 7) begin n_fail++; $display("FAIL release_level_fall: got %0d want 7", f); end
    endtask

    task automatic test_bounce();
        logic [31:0] m;
        logic [5:0]  pat;
        int r, f;
        int bounce_pulses;
        mode = 1'b0; run = 1'b1;
        pat = 6'b101101;
        bounce_pulses = 0;
        for (int i = 0; i < 5; i++) begin
            btn = pat[5 - i];
            step();
            if (en4) bounce_pulses++;
        end
        btn = pat[0];
        observe(20, m, r, f);
        n_checks++;
        if (bounce_pulses !== 0) begin n_fail++; $display("FAIL bounce_early_pulse: got %0d want 0", bounce_pulses); end
        n_checks++;
        if (m !== 32'h0000_0080) begin n_fail++; $display("FAIL bounce_pulse_mask: got %h want 00000080", m); end
        btn = 1'b0;
        observe(20, m, r, f);
        btn = 1'b1;
        repeat (3) step();
        btn = 1'b0;
        observe(20, m, r, f);
        n_checks++;
        if (m !== 32'h0 || r !== -1) begin
            n_fail++; $display("FAIL glitch_rejected: mask %h rise %0d want mask 0 rise -1", m, r);
        end
    endtask

    task automatic test_prescaler();
        logic [31:0] m;
        int r, f;
        mode = 1'b0; run = 1'b1; btn = 1'b0;
        step();
        mode = 1'b1;
        observe(16, m, r, f);
        n_checks++;
        if (m !== 32'h0001_1110) begin n_fail++; $display("FAIL prescale_period: got %h want 00011110", m); end
        observe(2, m, r, f);
        run = 1'b0;
        observe(5, m, r, f);
        n_checks++;
        if (m !== 32'h0) begin n_fail++; $display("FAIL prescale_paused: got %h want 0", m); end
        run = 1'b1;
        observe(8, m, r, f);
        n_checks++;
        if (m !== 32'h0000_0044) begin n_fail++; $display("FAIL prescale_resume_phase: got %h want 00000044", m); end
    endtask

    task automatic test_gating();
        logic [31:0] m;
        int r, f;
        mode = 1'b0; run = 1'b1; btn = 1'b0;
        step();
        mode = 1'b1;
        btn = 1'b1;
        observe(20, m, r, f);
        n_checks++;
        if (m !== 32'h0011_1110) begin n_fail++; $display("FAIL gate_press_in_prescale: got %h want 00111110", m); end
        n_checks++;
        if (r !== 7) begin n_fail++; $display("FAIL gate_level_rise_prescale: got %0d want 7", r); end
        mode = 1'b0; run = 1'b0;
        btn = 1'b0;
        observe(20, m, r, f);
        n_checks++;
        if (m !== 32'h0 || f !== 7) begin
            n_fail++; $display("FAIL gate_release_paused: mask %h fall %0d want mask 0 fall 7", m, f);
        end
        btn = 1'b1;
        observe(20, m, r, f);
        n_checks++;
        if (m !== 32'h0 || r !== 7) begin
            n_fail++; $display("FAIL gate_press_paused: mask %h rise %0d want mask 0 rise 7", m, r);
        end
        btn = 1'b0;
        observe(20, m, r, f);
    endtask

    task automatic test_div1_and_async_reset();
        int high_cycles;
        mode = 1'b1; run = 1'b1;
        high_cycles = 0;
        for (int c = 1; c <= 10; c++) begin
            step();
            if (en1) high_cycles++;
        end
        n_checks++;
        if (high_cycles !== 10) begin n_fail++; $display("FAIL div1_continuous: got %0d want 10", high_cycles); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (en1 !== 1'b0) begin n_fail++; $display("FAIL async_reset_div1: got %b want 0", en1); end
        n_checks++;
        if (en4 !== 1'b0 || lvl4 !== 1'b0) begin
            n_fail++; $display("FAIL async_reset_main: en %b lvl %b want 0 0", en4, lvl4);
        end
        step();
        rst_n = 1'b1;
        run = 1'b0;
        step();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n = 1'b0; btn = 1'b0; mode = 1'b0; run = 1'b0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_prescaler();
        test_gating();
        test_div1_and_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
